// File: rtl/seq_gen_tx.sv
// Birthday-pattern serial transmitter: sends N frames of a 9-bit pattern LSB-first with zero gaps.
// Optional continuous mode (frame count 0 repeats until abort) under SEQ_GEN_TX_CONTINUOUS_EN.
module seq_gen_tx #(
    parameter logic [8:0] BDAY_PATTERN = 9'b100000101,
    parameter int         GAP_W        = 8,
    parameter int         CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_frame_count,
    input  logic [GAP_W-1:0] i_gap_bits,
    input  logic             i_abort,
    output logic             o_serial_out,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_frames_sent
);
    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

    state_t           r_state;
    logic [3:0]       r_idx;
    logic [GAP_W-1:0] r_gap;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [CNT_W-1:0] r_frames_left;
    logic [CNT_W-1:0] r_frames_sent;
    logic             r_cont;
    logic             r_serial;
    logic             r_busy;
    logic             r_done;

    logic             w_cont;
    logic             w_last;
    logic [3:0]       w_idx_nxt;

`ifdef SEQ_GEN_TX_CONTINUOUS_EN
    assign w_cont = (i_frame_count == '0);
`else
    assign w_cont = 1'b0;
`endif

    // r_frames_left is already decremented when the frame's last bit is driven
    assign w_last    = !r_cont && (r_frames_left == '0);
    assign w_idx_nxt = r_idx + 4'd1;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_gap         <= '0;
            r_gap_cnt     <= '0;
            r_frames_left <= '0;
            r_frames_sent <= '0;
            r_cont        <= 1'b0;
            r_serial      <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_serial <= 1'b0;
                    r_busy   <= 1'b0;
                    if (i_start && !i_abort) begin
                        r_frames_left <= i_frame_count;
                        r_gap         <= i_gap_bits;
                        r_cont        <= w_cont;
                        r_frames_sent <= '0;
                        r_idx         <= '0;
                        r_gap_cnt     <= '0;
                        if (i_frame_count == '0 && !w_cont) begin
                            r_state <= DONE;
                        end else begin
                            r_state  <= SHIFT;
                            r_serial <= BDAY_PATTERN[0];
                            r_busy   <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (i_abort) begin
                        r_state  <= IDLE;
                        r_serial <= 1'b0;
                        r_busy   <= 1'b0;
                    end else if (r_idx == 4'd8) begin
                        if (w_last) begin
                            r_state  <= DONE;
                            r_serial <= 1'b0;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                        end else if (r_gap == '0) begin
                            r_idx    <= '0;
                            r_serial <= BDAY_PATTERN[0];
                        end else begin
                            r_state   <= GAP;
                            r_serial  <= 1'b0;
                            r_gap_cnt <= GAP_W'(1);
                        end
                    end else begin
                        r_idx    <= w_idx_nxt;
                        r_serial <= BDAY_PATTERN[w_idx_nxt];
                        if (w_idx_nxt == 4'd8) begin
                            if (r_frames_sent != '1)
                                r_frames_sent <= r_frames_sent + CNT_W'(1);
                            if (!r_cont)
                                r_frames_left <= r_frames_left - CNT_W'(1);
                        end
                    end
                end
                GAP: begin
                    if (i_abort) begin
                        r_state  <= IDLE;
                        r_serial <= 1'b0;
                        r_busy   <= 1'b0;
                    end else if (r_gap_cnt == r_gap) begin
                        r_state  <= SHIFT;
                        r_idx    <= '0;
                        r_serial <= BDAY_PATTERN[0];
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                        r_serial  <= 1'b0;
                    end
                end
                DONE: begin
                    // Entered from SHIFT with the pulse already up; an empty run enters
                    // with it low and raises it here, landing two cycles after start.
                    r_serial <= 1'b0;
                    r_busy   <= 1'b0;
                    if (r_done)
                        r_state <= IDLE;
                    else
                        r_done <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_serial_out  = r_serial;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_frames_sent = r_frames_sent;
endmodule

// File: tb/tb_seq_gen_tx.sv
// Directed bench for seq_gen_tx; inputs change and outputs are sampled 1 time unit after posedge.
module tb_seq_gen_tx;
    localparam int CNT_W = 16;
    localparam int GAP_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] frame_count = '0;
    logic [GAP_W-1:0] gap_bits = '0;
    logic             abort = 1'b0;
    logic             serial_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] frames_sent;

    int n_cmp = 0;
    int n_bad = 0;
    logic [8:0] pat = 9'b100000101;

    seq_gen_tx dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_frame_count(frame_count),
        .i_gap_bits(gap_bits), .i_abort(abort), .o_serial_out(serial_out),
        .o_busy(busy), .o_done(done), .o_frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int cnt, input int gap);
        frame_count = CNT_W'(cnt);
        gap_bits    = GAP_W'(gap);
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_cmp++;
        if ({serial_out, busy, done, frames_sent} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got ser=%b busy=%b done=%b sent=%0d, want all 0",
                     serial_out, busy, done, frames_sent);
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_frame();
        int bad_bits = 0;
        start_run(1, 0);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) tick();
            if (serial_out !== pat[i] || busy !== 1'b1) bad_bits++;
        end
        n_cmp++;
        if (bad_bits != 0) begin
            n_bad++;
            $display("FAIL single_bits: %0d bit/busy errors, want 0", bad_bits);
        end
        n_cmp++;
        if (frames_sent !== 16'd1) begin
            n_bad++;
            $display("FAIL single_sent: got %0d want 1", frames_sent);
        end
        tick();
        n_cmp++;
        if (done !== 1'b1 || serial_out !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL single_done: got done=%b ser=%b busy=%b want 1 0 0", done, serial_out, busy);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL single_done_pulse: done still %b after one cycle", done);
        end
    endtask

    task automatic test_multi_frame_gap();
        logic [8:0] sr = '0;
        int hits = 0, busy_cnt = 0, done_at = -1, line_err = 0;
        logic exp_bit;
        start_run(3, 4);
        for (int c = 0; c < 40; c++) begin
            if (c > 0) tick();
            sr = {serial_out, sr[8:1]};
            if (sr == pat) hits++;
            if (busy) busy_cnt++;
            if (done) done_at = c;
            exp_bit = (c < 35 && (c % 13) < 9) ? pat[c % 13] : 1'b0;
            if (serial_out !== exp_bit) line_err++;
        end
        n_cmp++;
        if (hits != 3) begin n_bad++; $display("FAIL multi_rx_hits: got %0d want 3", hits); end
        n_cmp++;
        if (busy_cnt != 35) begin n_bad++; $display("FAIL multi_busy: got %0d want 35", busy_cnt); end
        n_cmp++;
        if (line_err != 0) begin n_bad++; $display("FAIL multi_line: %0d bit errors want 0", line_err); end
        n_cmp++;
        if (frames_sent !== 16'd3) begin n_bad++; $display("FAIL multi_sent: got %0d want 3", frames_sent); end
        n_cmp++;
        if (done_at != 35) begin n_bad++; $display("FAIL multi_done_cycle: got %0d want 35", done_at); end
    endtask

    task automatic test_abort();
        int done_seen = 0;
        start_run(5, 0);
        for (int c = 1; c <= 22; c++) tick();
        n_cmp++;
        if (serial_out !== pat[4] || frames_sent !== 16'd2) begin
            n_bad++;
            $display("FAIL abort_pre: got ser=%b sent=%0d want %b 2", serial_out, frames_sent, pat[4]);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || serial_out !== 1'b0 || done !== 1'b0 || frames_sent !== 16'd2) begin
            n_bad++;
            $display("FAIL abort_idle: got busy=%b ser=%b done=%b sent=%0d want 0 0 0 2",
                     busy, serial_out, done, frames_sent);
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            if (done || busy || serial_out) done_seen++;
        end
        n_cmp++;
        if (done_seen != 0) begin n_bad++; $display("FAIL abort_quiet: %0d active cycles want 0", done_seen); end
    endtask

    task automatic test_start_ignored();
        int done_at = -1;
        start_run(2, 3);
        for (int c = 1; c <= 10; c++) tick();
        frame_count = 16'd9;
        gap_bits    = 8'd0;
        start       = 1'b1;
        tick();
        start       = 1'b0;
        if (done) done_at = 11;
        for (int c = 12; c <= 40; c++) begin
            tick();
            if (done && done_at < 0) done_at = c;
        end
        n_cmp++;
        if (done_at != 21) begin n_bad++; $display("FAIL ignore_done_cycle: got %0d want 21", done_at); end
        n_cmp++;
        if (frames_sent !== 16'd2) begin n_bad++; $display("FAIL ignore_sent: got %0d want 2", frames_sent); end
        frame_count = 16'd1;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || serial_out !== 1'b0 || frames_sent !== 16'd2) begin
            n_bad++;
            $display("FAIL start_abort_idle: got busy=%b ser=%b sent=%0d want 0 0 2", busy, serial_out, frames_sent);
        end
    endtask

    task automatic test_zero_count();
`ifdef SEQ_GEN_TX_CONTINUOUS_EN
        int err = 0;
        logic exp_bit;
        start_run(0, 2);
        for (int c = 0; c <= 32; c++) begin
            if (c > 0) tick();
            exp_bit = ((c % 11) < 9) ? pat[c % 11] : 1'b0;
            if (serial_out !== exp_bit || done !== 1'b0 || busy !== 1'b1) err++;
        end
        n_cmp++;
        if (err != 0) begin n_bad++; $display("FAIL cont_stream: %0d errors want 0", err); end
        n_cmp++;
        if (frames_sent !== 16'd3) begin n_bad++; $display("FAIL cont_sent: got %0d want 3", frames_sent); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || serial_out !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL cont_abort: got busy=%b ser=%b done=%b want 0 0 0", busy, serial_out, done);
        end
`else
        start_run(0, 0);
        n_cmp++;
        if (done !== 1'b0 || serial_out !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_early: got done=%b ser=%b want 0 0", done, serial_out);
        end
        tick();
        n_cmp++;
        if (done !== 1'b1 || serial_out !== 1'b0 || busy !== 1'b0 || frames_sent !== 16'd0) begin
            n_bad++;
            $display("FAIL zero_done: got done=%b ser=%b busy=%b sent=%0d want 1 0 0 0",
                     done, serial_out, busy, frames_sent);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL zero_pulse: done=%b want 0", done); end
`endif
    endtask

    task automatic test_async_reset();
        start_run(3, 0);
        for (int c = 1; c <= 11; c++) tick();
        n_cmp++;
        if (serial_out !== pat[2] || frames_sent !== 16'd1) begin
            n_bad++;
            $display("FAIL areset_pre: got ser=%b sent=%0d want %b 1", serial_out, frames_sent, pat[2]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({serial_out, busy, done, frames_sent} !== '0) begin
            n_bad++;
            $display("FAIL areset_async: got ser=%b busy=%b done=%b sent=%0d want all 0",
                     serial_out, busy, done, frames_sent);
        end
        #3;
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || serial_out !== 1'b0) begin
            n_bad++;
            $display("FAIL areset_idle: got busy=%b ser=%b want 0 0", busy, serial_out);
        end
        start_run(1, 0);
        n_cmp++;
        if (serial_out !== pat[0] || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL areset_restart: got ser=%b busy=%b want %b 1", serial_out, busy, pat[0]);
        end
        for (int c = 1; c <= 9; c++) tick();
        n_cmp++;
        if (done !== 1'b1 || frames_sent !== 16'd1) begin
            n_bad++;
            $display("FAIL areset_rerun: got done=%b sent=%0d want 1 1", done, frames_sent);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_multi_frame_gap();
        test_abort();
        test_start_ignored();
        test_zero_count();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/seq_gen_tx.md
Name: seq_gen_tx

Overview:
- Transmitter end of the birthday-pattern serial link.
- Serializes a fixed 9-bit pattern LSB-first onto a single-bit line, one bit per i_clk cycle (10 kHz system clock).
- Sends a programmed number of frames, with a programmable idle gap of zeros between frames.
- Drives the pattern-detector receiver directly. Used as stimulus source and traffic generator on the board.

Parameters:
- BDAY_PATTERN, 9'b100000101, frame pattern; bit 0 is transmitted first.
- GAP_W, 8, width of the inter-frame gap length field.
- CNT_W, 16, width of the frame-count request and the frames-sent counter.

Ports:
- i_clk  input  1  system clock, 10 kHz.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_start  input  1  request pulse; sampled only in IDLE.
- i_frame_count  input  CNT_W  number of frames to send; latched on accepted start.
- i_gap_bits  input  GAP_W  zero bits inserted between frames; latched on accepted start.
- i_abort  input  1  synchronous abort; terminates the run.
- o_serial_out  output  1  serial data, registered; idle level 0.
- o_busy  output  1  high from the cycle after accepted start until return to IDLE.
- o_done  output  1  one-cycle pulse at normal run completion.
- o_frames_sent  output  CNT_W  complete frames sent in the current or last run.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - o_serial_out=0, o_busy=0, o_done=0, o_frames_sent=0.
  - Internal bit index, gap counter and frame counter cleared.
- Reset mid-run returns to IDLE immediately. No o_done is produced.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - o_serial_out=0.
  - On i_start=1 with i_abort=0: latch i_frame_count and i_gap_bits, clear o_frames_sent.
  - If latched count==0: go to DONE. Otherwise go to SHIFT with bit index 0.
- SHIFT:
  - o_serial_out = BDAY_PATTERN[idx], registered.
  - The first bit appears on o_serial_out the cycle after i_start is sampled.
  - idx increments 0..8, one bit per cycle.
  - On the cycle bit 8 is driven, o_frames_sent increments.
  - After bit 8:
    - last frame -> DONE (no trailing gap);
    - else gap==0 -> SHIFT with idx=0 (back-to-back frames);
    - else -> GAP.
- GAP:
  - o_serial_out=0 for exactly the latched gap count in cycles.
  - Then SHIFT with idx=0.
- DONE:
  - o_done=1 for one cycle, o_serial_out=0, o_busy=0.
  - Next state IDLE.
- Frame period = 9 + gap cycles.
- Run length for N>0 frames = 9N + gap*(N-1) cycles of SHIFT/GAP.
- i_start while not in IDLE: ignored; latched values are unaffected.
- i_abort in SHIFT/GAP:
  - Next cycle: state=IDLE, o_serial_out=0, o_busy=0, no o_done.
  - o_frames_sent holds the count of complete frames.
- i_abort in IDLE: takes priority over a simultaneous i_start; the start is dropped.
- o_frames_sent saturates at all-ones and does not wrap.
- Bit order must match a receiver shifting {in, sr[8:1]}: after 9 bits, receiver sr == BDAY_PATTERN.

Optional Feature:
- Macro: SEQ_GEN_TX_CONTINUOUS_EN.
- Defined:
  - Latched i_frame_count==0 means continuous mode: frames repeat with the programmed gap until i_abort.
  - The last-frame test is never true. o_done is never pulsed in this mode.
  - o_frames_sent saturates.
- Undefined:
  - i_frame_count==0 goes IDLE -> DONE: o_done pulses 2 cycles after start, no bits sent.

Test Plan:
- Reset with i_reset_n low mid-SHIFT (async, between clock edges) -> all outputs 0 immediately; IDLE after release; next i_start accepted normally.
- i_frame_count=1, i_gap_bits=0, start -> o_serial_out sequence 1,0,1,0,0,0,0,0,1 starting 1 cycle after start; o_frames_sent=1; o_done pulses on the cycle after the last bit.
- i_frame_count=3, i_gap_bits=4 -> 35 busy data cycles with 4 zeros between frames. A connected receiver model counts exactly 3 hits and o_frames_sent=3.
- i_frame_count=5, gap=0; i_abort asserted during frame 3 bit 4 -> IDLE next cycle; o_frames_sent=2; no o_done; line 0.
- i_start re-pulsed during GAP with new i_frame_count=9 -> ignored; the run completes with the original count. Simultaneous i_start + i_abort in IDLE -> stays IDLE.
- i_frame_count=0:
  - macro undefined -> o_done pulses with no data bits;
  - macro defined, gap=2 -> frames repeat every 11 cycles until abort, no o_done.
